cam_param: RTL and testbench
============================

Name: cam_param

Overview:
- Parametrised successor to the team's 32x32 CAM.
- Adds:
  - configurable depth and width
  - ternary (masked) search
  - registered search pipeline with multi-hit flag and hit count
  - per-entry invalidate
  - sequenced flush
  - free-slot / full reporting
- Sits beside the existing CAM for lookup tables whose size or mask requirements differ.

Parameters:
- DEPTH, 32, number of entries; power of 2, 2..256.
- WIDTH, 32, bits per entry, 1..64.
- IDXW, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_i  input  1  asynchronous, active-low reset.
- write_enable_i  input  1  write write_data_i into entry write_index_i; sets its valid bit.
- write_index_i  input  IDXW  write/invalidate target.
- write_data_i  input  WIDTH  write data.
- invalidate_i  input  1  clear valid bit of entry write_index_i.
- flush_i  input  1  start clearing all valid bits.
- busy_o  output  1  flush in progress.
- read_index_i  input  IDXW  read address.
- read_value_o  output  WIDTH  combinational data of entry read_index_i.
- read_valid_o  output  1  combinational valid bit of entry read_index_i.
- search_enable_i  input  1  launch search this cycle.
- search_data_i  input  WIDTH  search key.
- search_mask_i  input  WIDTH  1 = compare bit, 0 = don't care.
- search_valid_o  output  1  registered: at least one hit.
- search_index_o  output  IDXW  registered: lowest matching index.
- search_multi_o  output  1  registered: two or more hits.
- search_count_o  output  IDXW+1  registered: number of hits.
- full_o  output  1  all entries valid.
- free_index_o  output  IDXW  lowest invalid index; 0 when full.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - all valid bits 0; data storage not reset.
  - search_valid_o=0, search_index_o=0, search_multi_o=0, search_count_o=0.
  - busy_o=0, FSM=IDLE.
  - After reset: full_o=0, free_index_o=0.
- Write:
  - Takes effect at the clock edge; visible on read ports the following cycle.
  - Write has priority over invalidate to the same cycle's index: entry ends valid with new data.
- Invalidate clears the valid bit only; data is retained.
- Match rule: entry j hits when valid[j] && ((data[j] ^ search_data_i) & search_mask_i) == 0.
  - Mask all-zero hits every valid entry.
- Search latency is 1 cycle: inputs sampled at edge N, results on search outputs after edge N.
  - Results hold until the next search_enable_i or reset.
  - search_enable_i=0 does not clear the outputs.
- Search vs. write in the same cycle: the search compares pre-write contents.
- Priority: lowest matching index wins.
- search_count_o saturates naturally: max DEPTH, and the width holds DEPTH.
- No hit:
  - search_valid_o=0, search_index_o=0, search_multi_o=0, search_count_o=0.
- FSM states IDLE and FLUSH:
  - IDLE -> FLUSH on flush_i: counter=0, busy_o=1 the next cycle.
  - FLUSH clears valid[counter] each cycle and increments counter.
  - After clearing DEPTH-1, returns to IDLE; busy_o=0.
  - Flush takes exactly DEPTH cycles.
- While busy_o=1:
  - write_enable_i, invalidate_i and flush_i are ignored.
  - search_enable_i is accepted but forces search_valid_o=0 and search_count_o=0.
- flush_i in IDLE together with write_enable_i: flush wins; the write is dropped.
- Reset mid-flush: FSM returns to IDLE immediately; all valid bits 0.
- full_o and free_index_o are combinational from the valid bits.
- Indices are always in range (DEPTH is a power of 2); no wrap handling is needed.

Test Plan:
- Reset, then write 0xDEADBEEF to index 5 and search 0xDEADBEEF with mask 0xFFFFFFFF -> one cycle later:
  - search_valid_o=1, search_index_o=5, search_count_o=1, search_multi_o=0.
  - read_index_i=5 gives read_value_o=0xDEADBEEF, read_valid_o=1.
- Write 0x12340001 to index 3 and 0x12340002 to index 9; search 0x12340000 with mask 0xFFFF0000 -> search_valid_o=1, search_index_o=3, search_multi_o=1, search_count_o=2.
- Invalidate index 3, then repeat the same search -> search_index_o=9, search_count_o=1; free_index_o=0 while entry 0 is free.
- Fill all 32 entries -> full_o=1, free_index_o=0.
  - Assert flush_i -> busy_o=1 for exactly 32 cycles, then full_o=0.
  - Any search during the flush returns search_valid_o=0.
  - A write during the flush is ignored.
- Same cycle: write 0xAAAA5555 to index 7 while searching 0xAAAA5555 with entry 7 previously invalid -> no hit. Repeat the search next cycle -> hit at index 7.
- Deassert rst_i for one cycle during a flush at counter 10 -> immediately busy_o=0, all read_valid_o=0, search outputs 0.
  - After release, a write and search to index 0 behave normally.

Source files
------------

// File: rtl/cam_param.sv
// Parametrised ternary CAM with a registered search stage, multi-hit count,
// per-entry invalidate, a sequenced flush and free-slot reporting.
module cam_param #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              write_enable_i,
    input  logic [IDXW-1:0]   write_index_i,
    input  logic [WIDTH-1:0]  write_data_i,
    input  logic              invalidate_i,
    input  logic              flush_i,
    output logic              busy_o,
    input  logic [IDXW-1:0]   read_index_i,
    output logic [WIDTH-1:0]  read_value_o,
    output logic              read_valid_o,
    input  logic              search_enable_i,
    input  logic [WIDTH-1:0]  search_data_i,
    input  logic [WIDTH-1:0]  search_mask_i,
    output logic              search_valid_o,
    output logic [IDXW-1:0]   search_index_o,
    output logic              search_multi_o,
    output logic [IDXW:0]     search_count_o,
    output logic              full_o,
    output logic [IDXW-1:0]   free_index_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state;
    logic [IDXW-1:0]   flush_cnt;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  hit;
    logic [IDXW-1:0]   hit_index;
    logic [IDXW:0]     hit_count;
    logic              hit_found;
    logic              free_found;
    logic              do_write;

    // A write is accepted only in IDLE and only when no flush starts this cycle.
    assign do_write = (state == IDLE) && !flush_i && write_enable_i;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[write_index_i] <= write_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            flush_cnt <= '0;
            valid     <= '0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_i) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                        busy_o    <= 1'b1;
                    end else if (write_enable_i) begin
                        valid[write_index_i] <= 1'b1;
                    end else if (invalidate_i) begin
                        valid[write_index_i] <= 1'b0;
                    end
                end
                FLUSH: begin
                    valid[flush_cnt] <= 1'b0;
                    flush_cnt        <= flush_cnt + IDXW'(1);
                    if (flush_cnt == IDXW'(DEPTH - 1)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            hit[j] = valid[j] && (((mem[j] ^ search_data_i) & search_mask_i) == '0);
        end
    end

    // Lowest-index priority encode and population count share one pass.
    always_comb begin
        hit_index = '0;
        hit_count = '0;
        hit_found = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (hit[j]) begin
                if (!hit_found) begin
                    hit_index = IDXW'(j);
                end
                hit_found = 1'b1;
                hit_count = hit_count + (IDXW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            search_valid_o <= 1'b0;
            search_index_o <= '0;
            search_multi_o <= 1'b0;
            search_count_o <= '0;
        end else if (search_enable_i) begin
            if (busy_o) begin
                search_valid_o <= 1'b0;
                search_index_o <= '0;
                search_multi_o <= 1'b0;
                search_count_o <= '0;
            end else begin
                search_valid_o <= hit_found;
                search_index_o <= hit_index;
                search_multi_o <= (hit_count > (IDXW+1)'(1));
                search_count_o <= hit_count;
            end
        end
    end

    always_comb begin
        free_index_o = '0;
        free_found   = 1'b0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (!valid[j] && !free_found) begin
                free_index_o = IDXW'(j);
                free_found   = 1'b1;
            end
        end
    end

    assign full_o       = &valid;
    assign read_value_o = mem[read_index_i];
    assign read_valid_o = valid[read_index_i];

endmodule

// File: tb/tb_cam_param.sv
// Self-checking bench for cam_param: a vector table for single operations plus
// hand-written flush, same-cycle write/search and mid-flush reset sequences.
module tb_cam_param;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        write_enable_i;
    logic [4:0]  write_index_i;
    logic [31:0] write_data_i;
    logic        invalidate_i;
    logic        flush_i;
    logic        busy_o;
    logic [4:0]  read_index_i;
    logic [31:0] read_value_o;
    logic        read_valid_o;
    logic        search_enable_i;
    logic [31:0] search_data_i;
    logic [31:0] search_mask_i;
    logic        search_valid_o;
    logic [4:0]  search_index_o;
    logic        search_multi_o;
    logic [5:0]  search_count_o;
    logic        full_o;
    logic [4:0]  free_index_o;

    cam_param #(.DEPTH(32), .WIDTH(32)) dut (
        .clk(clk), .rst_i(rst_i),
        .write_enable_i(write_enable_i), .write_index_i(write_index_i),
        .write_data_i(write_data_i), .invalidate_i(invalidate_i),
        .flush_i(flush_i), .busy_o(busy_o),
        .read_index_i(read_index_i), .read_value_o(read_value_o),
        .read_valid_o(read_valid_o),
        .search_enable_i(search_enable_i), .search_data_i(search_data_i),
        .search_mask_i(search_mask_i), .search_valid_o(search_valid_o),
        .search_index_o(search_index_o), .search_multi_o(search_multi_o),
        .search_count_o(search_count_o),
        .full_o(full_o), .free_index_o(free_index_o)
    );

    always #5 clk = ~clk;

    typedef enum {OP_WR, OP_INV, OP_WRINV, OP_SRCH, OP_RD, OP_FREE} op_t;

    typedef struct {
        op_t         op;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [31:0] mask;
        logic        e_v;
        logic [4:0]  e_idx;
        logic        e_m;
        logic [5:0]  e_cnt;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic       v;
        logic [4:0] idx;
        logic       m;
        logic [5:0] cnt;
        bit         busy;
    } sres_t;

    sres_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    localparam int NV = 18;
    vec_t vt [NV];

    function automatic vec_t mk(op_t op, int idx, logic [31:0] d, logic [31:0] m,
                                logic ev, int eidx, logic em, int ecnt, logic [31:0] ed);
        vec_t r;
        r.op = op; r.idx = 5'(idx); r.data = d; r.mask = m;
        r.e_v = ev; r.e_idx = 5'(eidx); r.e_m = em; r.e_cnt = 6'(ecnt); r.e_data = ed;
        return r;
    endfunction

    function automatic sres_t sr(logic v, int idx, logic m, int cnt, bit busy);
        sres_t r;
        r.v = v; r.idx = 5'(idx); r.m = m; r.cnt = 6'(cnt); r.busy = busy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_search(input string name);
        sres_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({name, "_valid"}, 64'(search_valid_o), 64'(e.v));
            chk({name, "_count"}, 64'(search_count_o), 64'(e.cnt));
            if (!e.busy) begin
                chk({name, "_index"}, 64'(search_index_o), 64'(e.idx));
                chk({name, "_multi"}, 64'(search_multi_o), 64'(e.m));
            end
        end
    endtask

    task automatic do_search(input string name, input logic [31:0] d, input logic [31:0] m,
                             input sres_t e);
        search_enable_i = 1'b1;
        search_data_i   = d;
        search_mask_i   = m;
        sb.push_back(e);
        tick();
        search_enable_i = 1'b0;
        check_search(name);
    endtask

    task automatic do_write(input int idx, input logic [31:0] d);
        write_enable_i = 1'b1;
        write_index_i  = 5'(idx);
        write_data_i   = d;
        tick();
        write_enable_i = 1'b0;
    endtask

    initial begin
        int n;
        logic any_valid;

        rst_i = 1'b0; write_enable_i = 1'b0; write_index_i = '0; write_data_i = '0;
        invalidate_i = 1'b0; flush_i = 1'b0; read_index_i = '0;
        search_enable_i = 1'b0; search_data_i = '0; search_mask_i = '0;
        tick(); tick();
        rst_i = 1'b1;
        tick();

        chk("rst_busy",  64'(busy_o), 0);
        chk("rst_sv",    64'(search_valid_o), 0);
        chk("rst_sidx",  64'(search_index_o), 0);
        chk("rst_multi", 64'(search_multi_o), 0);
        chk("rst_cnt",   64'(search_count_o), 0);
        chk("rst_full",  64'(full_o), 0);
        chk("rst_free",  64'(free_index_o), 0);

        vt[0]  = mk(OP_WR,    5,  32'hDEADBEEF, '0,           0, 0, 0, 0, '0);
        vt[1]  = mk(OP_SRCH,  0,  32'hDEADBEEF, 32'hFFFFFFFF, 1, 5, 0, 1, '0);
        vt[2]  = mk(OP_RD,    5,  '0,           '0,           1, 0, 0, 0, 32'hDEADBEEF);
        vt[3]  = mk(OP_WR,    3,  32'h12340001, '0,           0, 0, 0, 0, '0);
        vt[4]  = mk(OP_WR,    9,  32'h12340002, '0,           0, 0, 0, 0, '0);
        vt[5]  = mk(OP_SRCH,  0,  32'h12340000, 32'hFFFF0000, 1, 3, 1, 2, '0);
        vt[6]  = mk(OP_INV,   3,  '0,           '0,           0, 0, 0, 0, '0);
        vt[7]  = mk(OP_SRCH,  0,  32'h12340000, 32'hFFFF0000, 1, 9, 0, 1, '0);
        vt[8]  = mk(OP_RD,    3,  '0,           '0,           0, 0, 0, 0, 32'h12340001);
        vt[9]  = mk(OP_FREE,  0,  '0,           '0,           0, 0, 0, 0, '0);
        vt[10] = mk(OP_SRCH,  0,  32'h00000000, 32'h00000000, 1, 5, 1, 2, '0);
        vt[11] = mk(OP_SRCH,  0,  32'h11111111, 32'hFFFFFFFF, 0, 0, 0, 0, '0);
        vt[12] = mk(OP_WRINV, 4,  32'h00000044, '0,           0, 0, 0, 0, '0);
        vt[13] = mk(OP_RD,    4,  '0,           '0,           1, 0, 0, 0, 32'h00000044);
        vt[14] = mk(OP_WR,    0,  32'h00000000, '0,           0, 0, 0, 0, '0);
        vt[15] = mk(OP_FREE,  0,  '0,           '0,           0, 1, 0, 0, '0);
        vt[16] = mk(OP_SRCH,  0,  32'h00000000, 32'hFFFF0000, 1, 0, 1, 2, '0);
        vt[17] = mk(OP_SRCH,  0,  32'h00000002, 32'h0000000F, 1, 9, 0, 1, '0);

        for (int i = 0; i < NV; i++) begin
            case (vt[i].op)
                OP_WR: do_write(int'(vt[i].idx), vt[i].data);
                OP_INV: begin
                    invalidate_i = 1'b1; write_index_i = vt[i].idx;
                    tick();
                    invalidate_i = 1'b0;
                end
                OP_WRINV: begin
                    invalidate_i = 1'b1;
                    do_write(int'(vt[i].idx), vt[i].data);
                    invalidate_i = 1'b0;
                end
                OP_SRCH: do_search($sformatf("vec%0d", i), vt[i].data, vt[i].mask,
                                   sr(vt[i].e_v, int'(vt[i].e_idx), vt[i].e_m, int'(vt[i].e_cnt), 0));
                OP_RD: begin
                    read_index_i = vt[i].idx;
                    #1;
                    chk($sformatf("vec%0d_rdata", i), 64'(read_value_o), 64'(vt[i].e_data));
                    chk($sformatf("vec%0d_rvalid", i), 64'(read_valid_o), 64'(vt[i].e_v));
                end
                OP_FREE: begin
                    chk($sformatf("vec%0d_full", i), 64'(full_o), 64'(vt[i].e_v));
                    chk($sformatf("vec%0d_free", i), 64'(free_index_o), 64'(vt[i].e_idx));
                end
                default: ;
            endcase
        end

        // results hold while search_enable_i is low
        tick();
        chk("hold_sv",  64'(search_valid_o), 1);
        chk("hold_idx", 64'(search_index_o), 9);
        chk("hold_cnt", 64'(search_count_o), 1);

        for (int i = 0; i < 32; i++) do_write(i, 32'hC0DE0000 | 32'(i));
        chk("fill_full", 64'(full_o), 1);
        chk("fill_free", 64'(free_index_o), 0);

        // flush together with a write: the write must be dropped
        flush_i = 1'b1; write_enable_i = 1'b1; write_index_i = 5'd1; write_data_i = 32'hFFFFFFFF;
        tick();
        flush_i = 1'b0; write_enable_i = 1'b0;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            if (n == 3) begin
                search_enable_i = 1'b1; search_data_i = 32'hC0DE0014; search_mask_i = 32'hFFFFFFFF;
                sb.push_back(sr(0, 0, 0, 0, 1));
            end
            if (n == 5) begin
                write_enable_i = 1'b1; write_index_i = 5'd2; write_data_i = 32'h00000BAD;
            end
            tick();
            if (n == 3) begin
                search_enable_i = 1'b0;
                check_search("busy_search");
            end
            if (n == 5) write_enable_i = 1'b0;
        end
        chk("flush_cycles", 64'(n), 32);
        chk("flush_full", 64'(full_o), 0);
        chk("flush_free", 64'(free_index_o), 0);
        read_index_i = 5'd2;
        #1;
        chk("busy_wr_valid", 64'(read_valid_o), 0);
        chk("busy_wr_data",  64'(read_value_o), 64'h00000000C0DE0002);
        read_index_i = 5'd1;
        #1;
        chk("flush_wr_drop", 64'(read_value_o), 64'h00000000C0DE0001);
        do_search("post_flush", 32'h0, 32'h0, sr(0, 0, 0, 0, 0));

        // write and search in the same cycle compare pre-write contents
        write_enable_i = 1'b1; write_index_i = 5'd7; write_data_i = 32'hAAAA5555;
        do_search("same_cycle", 32'hAAAA5555, 32'hFFFFFFFF, sr(0, 0, 0, 0, 0));
        write_enable_i = 1'b0;
        do_search("next_cycle", 32'hAAAA5555, 32'hFFFFFFFF, sr(1, 7, 0, 1, 0));

        // asynchronous reset in the middle of a flush
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("mid_busy_pre", 64'(busy_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 0);
        chk("mid_rst_sv",   64'(search_valid_o), 0);
        chk("mid_rst_sidx", 64'(search_index_o), 0);
        chk("mid_rst_cnt",  64'(search_count_o), 0);
        chk("mid_rst_multi",64'(search_multi_o), 0);
        any_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_index_i = 5'(i);
            #0.1;
            any_valid = any_valid | read_valid_o;
        end
        chk("mid_rst_valid", 64'(any_valid), 0);
        tick();
        rst_i = 1'b1;
        tick();
        chk("post_rst_busy", 64'(busy_o), 0);
        do_write(0, 32'h00000055);
        do_search("post_rst", 32'h00000055, 32'hFFFFFFFF, sr(1, 0, 0, 1, 0));
        read_index_i = 5'd0;
        #1;
        chk("post_rst_rdata",  64'(read_value_o), 64'h55);
        chk("post_rst_rvalid", 64'(read_valid_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
